// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a programmable wait latency.
// Optional access-error reporting is enabled with the MEM_RESP_ERR_EN macro.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request latched, counting down LATENCY wait cycles
// RESP  | response presented, held until rsp_ready
module mem_responder #(
   parameter int                 WIDTH      = 32,
   parameter int                 DEPTH_LOG2 = 10,
   parameter logic [WIDTH-1:0]   BASE       = 32'h8000_0000,
   parameter int                 LATENCY    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [WIDTH-1:0]     req_addr,
   input  logic [WIDTH-1:0]     req_wdata,
   input  logic [WIDTH/8-1:0]   req_wstrb,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH-1:0]     rsp_rdata
`ifdef MEM_RESP_ERR_EN
   ,
   output logic                 rsp_err
`endif
);

   localparam int NLANE = WIDTH / 8;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic [NLANE-1:0]      wstrb_q, wstrb_d;
   logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
   logic                  pend_err_q, pend_err_d;
   logic [WIDTH-1:0]      mem_q [DEPTH];

   logic [WIDTH-1:0]      offset;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  req_err;
   logic                  accept;
   logic                  enter_resp;
   logic                  sel_req;
   logic                  acc_we, acc_err;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [WIDTH-1:0]      acc_wdata;
   logic [NLANE-1:0]      acc_wstrb;
   logic                  mem_we;

   assign offset  = req_addr - BASE;
   assign req_idx = offset[DEPTH_LOG2+1:2];

`ifdef MEM_RESP_ERR_EN
   logic rsp_err_q, rsp_err_d;
   assign req_err = (req_addr[1:0] != 2'b00) || ((offset >> (DEPTH_LOG2 + 2)) != '0);
   assign rsp_err = rsp_err_q;
`else
   logic unused_addr_bits;
   assign req_err          = 1'b0;
   assign unused_addr_bits = ^{offset[1:0], offset[WIDTH-1:DEPTH_LOG2+2]};
`endif

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign accept    = req_valid & req_ready;

   // With zero latency the access happens on the accept edge, straight from the request inputs.
   assign sel_req    = (state_q == S_IDLE);
   assign enter_resp = (accept && (LATENCY == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
   assign acc_we     = sel_req ? req_we    : we_q;
   assign acc_err    = sel_req ? req_err   : pend_err_q;
   assign acc_idx    = sel_req ? req_idx   : idx_q;
   assign acc_wdata  = sel_req ? req_wdata : wdata_q;
   assign acc_wstrb  = sel_req ? req_wstrb : wstrb_q;
   assign mem_we     = enter_resp & acc_we & ~acc_err;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      pend_err_d = pend_err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d       = req_we;
               idx_d      = req_idx;
               wdata_d    = req_wdata;
               wstrb_d    = req_wstrb;
               pend_err_d = req_err;
               if (LATENCY == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rsp_rdata_d = rsp_rdata_q;
      if (enter_resp) rsp_rdata_d = (acc_we || acc_err) ? '0 : mem_q[acc_idx];
   end

`ifdef MEM_RESP_ERR_EN
   always_comb begin
      rsp_err_d = rsp_err_q;
      if (enter_resp) rsp_err_d = acc_err;
   end

   always_ff @(posedge clk) begin
      if (rst) rsp_err_q <= 1'b0;
      else     rsp_err_q <= rsp_err_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_rdata_q <= rsp_rdata_d;
         we_q        <= we_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         pend_err_q  <= pend_err_d;
      end
   end

   // Reset wins over a commit on the same edge, so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         for (int i = 0; i < NLANE; i++) begin
            if (acc_wstrb[i]) mem_q[acc_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, corner sequences, random vs. word model.
module tb_mem_responder;
   localparam int          LAT  = 2;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .BASE(BASE), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata)
`ifdef MEM_RESP_ERR_EN
      ,
      .rsp_err   (rsp_err)
`endif
   );

`ifndef MEM_RESP_ERR_EN
   assign rsp_err = 1'b0;
`endif

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] model[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] st, input logic [31:0] exp, input bit err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wd; v.strb = st; v.exp_rdata = exp; v.exp_err = err;
      return v;
   endfunction

   // Inputs change and outputs are sampled on the falling edge only.
   task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp, input bit exp_err,
                      input int hold, input string tag);
      int n;
      logic [31:0] rd;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
      check({tag, "_latency"}, n, LAT + 1);
      check({tag, "_rdata"}, rsp_rdata, exp);
      check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      rd = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
         check({tag, "_hold_rdata"}, rsp_rdata, rd);
         check({tag, "_hold_noready"}, {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_retire_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_retire_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int last, n_acc;
      bit we;
      int i, hold;
      logic [31:0] wd, exp, addr;
      logic [3:0]  st;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_wstrb = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_req_ready", {31'd0, req_ready}, 32'd1);
      check("reset_rdata", rsp_rdata, 32'd0);
      check("reset_err", {31'd0, rsp_err}, 32'd0);

      vecs.push_back(mk(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0));
      vecs.push_back(mk(0, 32'h8000_0010, 32'h0,        4'h0, 32'hDEAD_BEEF, 0));
      vecs.push_back(mk(1, 32'h8000_0014, 32'h1122_3344, 4'hF, 32'h0, 0));
      vecs.push_back(mk(1, 32'h8000_0014, 32'hAABB_CCDD, 4'h5, 32'h0, 0));
      vecs.push_back(mk(0, 32'h8000_0014, 32'h0,        4'h0, 32'h11BB_33DD, 0));
      vecs.push_back(mk(1, 32'h8000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0, 0));
      vecs.push_back(mk(0, 32'h8000_0014, 32'h0,        4'h0, 32'h11BB_33DD, 0));
      vecs.push_back(mk(1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 0));
`ifdef MEM_RESP_ERR_EN
      vecs.push_back(mk(0, 32'h8000_0002, 32'h0,        4'h0, 32'h0, 1));
      vecs.push_back(mk(1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0, 1));
      vecs.push_back(mk(0, 32'h8000_0000, 32'h0,        4'h0, 32'hCAFE_F00D, 0));
`else
      vecs.push_back(mk(0, 32'h8000_1000, 32'h0,        4'h0, 32'hCAFE_F00D, 0));
      vecs.push_back(mk(0, 32'h8000_0013, 32'h0,        4'h0, 32'hDEAD_BEEF, 0));
`endif
      foreach (vecs[k])
         txn(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].strb,
             vecs[k].exp_rdata, vecs[k].exp_err, 0, $sformatf("vec%0d", k));

      // Stalled response, then abort a write with reset while it waits.
      txn(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 5, "stall");
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0014;
      req_wdata = 32'h0BAD_0BAD; req_wstrb = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_rdata_cleared", rsp_rdata, 32'd0);
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      for (int c = 0; c < 5; c++) begin
         check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
         @(negedge clk);
      end
      txn(0, 32'h8000_0014, 32'h0, 4'h0, 32'h11BB_33DD, 0, 0, "abort_word_kept");

      // Back-to-back reads: one accept every LAT+2 cycles.
      rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010;
      last = -1; n_acc = 0;
      for (int cyc = 0; cyc < 41; cyc++) begin
         if (req_valid && req_ready) begin
            if (last >= 0) check("b2b_interval", cyc - last, LAT + 2);
            last = cyc;
            n_acc++;
         end
         if (rsp_valid) check("b2b_rdata", rsp_rdata, 32'hDEAD_BEEF);
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_accepts", n_acc, 11);
      repeat (LAT + 3) @(negedge clk);
      rsp_ready = 1'b0;

      // Random traffic over eight words against a per-word model.
      for (int w = 0; w < 8; w++) begin
         model[w] = $urandom;
         txn(1, BASE + 32'(w * 4), model[w], 4'hF, 32'h0, 0, 0, "rinit");
      end
      for (int r = 0; r < 150; r++) begin
         i    = $urandom_range(0, 7);
         we   = 1'($urandom_range(0, 1));
         st   = 4'($urandom);
         wd   = $urandom;
         hold = $urandom_range(0, 2);
         addr = BASE + 32'(i * 4);
`ifndef MEM_RESP_ERR_EN
         addr = addr + 32'($urandom_range(0, 3));
`endif
         exp = we ? 32'h0 : model[i];
         txn(we, addr, wd, st, exp, 0, hold, $sformatf("rand%0d", r));
         if (we)
            for (int b = 0; b < 4; b++)
               if (st[b]) model[i][b*8 +: 8] = wd[b*8 +: 8];
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WIDTH, 32, data and byte-address width.
REQ-002 Parameter DEPTH_LOG2, 10, log2 of word count.
REQ-003 Parameter BASE, 32'h8000_0000, byte address of word 0.
REQ-004 Parameter LATENCY, 2, extra wait cycles before response (range 0..15).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  1  initiator presents request.
REQ-008 req_ready  output  1  responder accepts request.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  WIDTH  byte address.
REQ-011 req_wdata  input  WIDTH  write data.
REQ-012 req_wstrb  input  WIDTH/8  byte-lane write enables.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  initiator accepts response.
REQ-015 rsp_rdata  output  WIDTH  read data; 0 for writes.
REQ-016 rsp_err  output  1  access error (present only with MEM_RESP_ERR_EN).

Function
REQ-017 FSM states IDLE, WAIT, RESP; at most one transaction outstanding.
REQ-018 req_ready SHALL be 1 exactly when state is IDLE.
REQ-019 Accept = req_valid & req_ready; on accept latch we, addr, wdata, wstrb; go WAIT if LATENCY>0 else RESP.
REQ-020 WAIT: down-counter loaded with LATENCY-1 on accept; move to RESP when counter is 0, else decrement.
REQ-021 Accept in cycle T SHALL give rsp_valid=1 first in cycle T+1+LATENCY.
REQ-022 Memory access (read sample and byte-masked write) occurs on the edge entering RESP; rsp_rdata registered at that edge.
REQ-023 Word index = (addr - BASE) >> 2, truncated to DEPTH_LOG2 bits.
REQ-024 Write: only lanes with wstrb[i]=1 updated; wstrb=0 leaves the word unchanged; rsp_rdata=0.
REQ-025 RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_valid & rsp_ready; on that edge go IDLE.
REQ-026 No same-cycle response-retire/request-accept; peak throughput one transaction per LATENCY+2 cycles.
REQ-027 A read following a write to the same word SHALL return the written data.
REQ-028 Requests while req_ready=0 are ignored; initiator holds req_valid.

Reset
REQ-029 rst high at an edge SHALL force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-030 Reset mid-transaction SHALL abort it; a write not yet committed (state WAIT) SHALL NOT modify memory.
REQ-031 Memory array contents are not reset.
REQ-032 After the reset edge req_ready=1 (state IDLE).

Configuration
REQ-033 Macro MEM_RESP_ERR_EN defined: rsp_err port exists; err=1 if addr[1:0]!=0 or (addr-BASE) >= 4*2^DEPTH_LOG2; errored writes suppressed, errored reads return rsp_rdata=0.
REQ-034 Macro MEM_RESP_ERR_EN undefined: no rsp_err port; addr[1:0] ignored; out-of-range addresses wrap modulo depth per REQ-023.

Verification (LATENCY=2, defaults)
REQ-035 Write 0x8000_0010 data 0xDEADBEEF wstrb 0xF accepted cycle T -> rsp_valid at T+3, rsp_rdata 0; then read 0x8000_0010 -> 0xDEADBEEF.
REQ-036 Word holds 0x11223344; write 0xAABBCCDD wstrb 0x5 -> subsequent read returns 0x11BB33DD.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata constant, req_ready 0; rsp_ready=1 -> IDLE next cycle, req_ready 1.
REQ-038 Back-to-back reads with req_valid held 1, rsp_ready tied 1 -> one accept every 4 cycles.
REQ-039 Write accepted, rst pulsed one cycle in WAIT -> no rsp_valid, target word retains old value.
REQ-040 With MEM_RESP_ERR_EN: read 0x8000_0002 -> rsp_err 1, rsp_rdata 0; write 0x8000_1000 -> rsp_err 1, memory unchanged; without it read 0x8000_1000 returns word 0.
